// File: rtl/mtc_builder_arb_if.sv
// Candidate/pT inputs and MTC output stream of the MTC builder/arbiter.
interface mtc_builder_arb_if #(
  parameter int unsigned N_CAND         = 3,
  parameter int unsigned N_PTCALC       = 3,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned PL2MTC_LEN     = 26,
  parameter int unsigned PTCALC2MTC_LEN = 26,
  parameter int unsigned MTC2SL_LEN     = 40
);
  logic [N_CAND-1:0][PL2MTC_LEN-1:0]       i_slc;
  logic [N_PTCALC-1:0][PTCALC2MTC_LEN-1:0] i_ptcalc;
  logic [N_PTCALC-1:0]                     i_ptcalc_valid;
  logic [MTC2SL_LEN-1:0]                   o_mtc;
  logic                                    o_mtc_valid;
  logic                                    i_mtc_ready;
  logic [CNT_W-1:0]                        o_drop_cnt;
  logic                                    o_fifo_full;

  modport master (
    output i_slc, i_ptcalc, i_ptcalc_valid, i_mtc_ready,
    input  o_mtc, o_mtc_valid, o_drop_cnt, o_fifo_full
  );

  modport slave (
    input  i_slc, i_ptcalc, i_ptcalc_valid, i_mtc_ready,
    output o_mtc, o_mtc_valid, o_drop_cnt, o_fifo_full
  );
endinterface

// File: rtl/mtc_builder_arb.sv
// Per-lane MTC builder with priority arbitration into a FWFT output FIFO.
// Optional pT timeout enabled by defining MTC_BUILDER_TIMEOUT_EN.
module mtc_builder_arb #(
  parameter int unsigned N_CAND     = 3,
  parameter int unsigned N_PTCALC   = 3,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_W      = 16
) (
  input logic              clock,
  input logic              rst,
  mtc_builder_arb_if.slave io_mtc
);
  localparam int unsigned PL2MTC_LEN            = 26;
  localparam int unsigned PL2MTC_DATA_VALID_MSB = 25;
  localparam int unsigned PL2MTC_BUSY_LSB       = 24;
  localparam int unsigned PTCALC2MTC_LEN        = 26;
  localparam int unsigned MTC2SL_LEN            = 40;
  localparam int unsigned COMMON_W              = 20;
  localparam int unsigned CH_W                  = 2;
  localparam int unsigned COIN_W                = 2;
  localparam int unsigned PTR_W                 = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_SUM_W             = CNT_W + 1;
`ifdef MTC_BUILDER_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

  typedef enum logic [1:0] {IDLE, WAIT_PT, DONE} lane_state_t;

  function automatic logic [3:0] f_procflags(input logic [COMMON_W-1:0]       common,
                                             input logic [COIN_W-1:0]         coin,
                                             input logic [PTCALC2MTC_LEN-1:0] pt);
    logic [3:0] slid;
    logic [3:0] sl_pth;
    logic [7:0] ptv;
    logic [3:0] pth;
    logic [2:0] nseg;
    slid   = common[7:4];
    sl_pth = common[3:0];
    ptv    = pt[7:0];
    pth    = pt[11:8];
    nseg   = pt[25:23];
    if (slid != 4'd0)                    return 4'h3;
    else if (ptv != 8'd0)                return (pth >= sl_pth) ? 4'h1 : 4'h2;
    else if (coin == COIN_W'(0)) begin
      if (nseg == 3'd0)                  return 4'h4;
      else if (nseg == 3'd1)             return 4'h5;
      else                               return 4'hF;
    end
    else if (nseg > 3'd2)                return 4'h6;
    else                                 return 4'hF;
  endfunction

  // Layout: valid | reserved | procflags | quality..nseg | charge..eta | common
  function automatic logic [MTC2SL_LEN-1:0] f_word(input logic [COMMON_W-1:0] common,
                                                   input logic [8:0]          ce,
                                                   input logic [4:0]          qn,
                                                   input logic [3:0]          pf);
    return {1'b1, 1'b0, pf, qn, ce, common};
  endfunction

  logic [N_CAND-1:0]     w_done;
  logic [N_CAND-1:0]     w_drop;
  logic [N_CAND-1:0]     w_grant;
  logic [MTC2SL_LEN-1:0] w_word [N_CAND];
  logic                  w_push;
  logic [MTC2SL_LEN-1:0] w_push_word;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_can_push;

  for (genvar g = 0; g < N_CAND; g++) begin : g_lane
    lane_state_t                 r_state;
    logic [COMMON_W-1:0]         r_common;
    logic [COIN_W-1:0]           r_coin;
    logic [CH_W-1:0]             r_ch;
    logic [MTC2SL_LEN-1:0]       r_word;
    logic                        w_slc_v;
    logic                        w_busy;
    logic                        w_capture;
    logic                        w_hit;
    logic [PTCALC2MTC_LEN-1:0]   w_pt;
    logic [PL2MTC_LEN-1:0]       w_slc;
`ifdef MTC_BUILDER_TIMEOUT_EN
    logic [TMR_W-1:0]            r_timer;
    logic                        w_ch_ok;
    assign w_ch_ok   = 32'(r_ch) < N_PTCALC;
    assign w_capture = w_slc_v && !w_busy;
    assign w_drop[g] = w_slc_v && (r_state != IDLE);
`else
    logic                        w_in_ch_ok;
    assign w_in_ch_ok = 32'(w_slc[21:20]) < N_PTCALC;
    assign w_capture  = w_slc_v && !w_busy && w_in_ch_ok;
    assign w_drop[g]  = w_slc_v && ((r_state != IDLE) || (!w_busy && !w_in_ch_ok));
`endif

    assign w_slc     = io_mtc.i_slc[g];
    assign w_slc_v   = w_slc[PL2MTC_DATA_VALID_MSB];
    assign w_busy    = w_slc[PL2MTC_BUSY_LSB];
    assign w_done[g] = (r_state == DONE);
    assign w_word[g] = r_word;

    // Select the pT result of this lane's process channel.
    always_comb begin
      w_hit = 1'b0;
      w_pt  = '0;
      for (int unsigned p = 0; p < N_PTCALC; p++) begin
        if ((32'(r_ch) == p) && io_mtc.i_ptcalc_valid[p]) begin
          w_hit = 1'b1;
          w_pt  = io_mtc.i_ptcalc[p];
        end
      end
    end

    always_ff @(posedge clock) begin
      if (rst) begin
        r_state  <= IDLE;
        r_common <= '0;
        r_coin   <= '0;
        r_ch     <= '0;
        r_word   <= '0;
`ifdef MTC_BUILDER_TIMEOUT_EN
        r_timer  <= '0;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (w_slc_v && w_busy) begin
              r_word  <= f_word(w_slc[COMMON_W-1:0], '0, '0, 4'h0);
              r_state <= DONE;
            end else if (w_capture) begin
              r_common <= w_slc[COMMON_W-1:0];
              r_coin   <= w_slc[23:22];
              r_ch     <= w_slc[21:20];
              r_state  <= WAIT_PT;
`ifdef MTC_BUILDER_TIMEOUT_EN
              r_timer  <= '0;
`endif
            end
          end
          WAIT_PT: begin
            if (w_hit) begin
              r_word  <= f_word(r_common, w_pt[20:12], w_pt[25:21],
                                f_procflags(r_common, r_coin, w_pt));
              r_state <= DONE;
            end
`ifdef MTC_BUILDER_TIMEOUT_EN
            else if (!w_ch_ok || (r_timer == TMR_W'(TIMEOUT - 1))) begin
              r_word  <= f_word(r_common, '0, '0, 4'hE);
              r_state <= DONE;
            end else if (r_timer != '1) begin
              r_timer <= r_timer + TMR_W'(1);
            end
`endif
          end
          DONE: begin
            if (w_grant[g]) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Lowest-index finished lane takes the single FIFO write slot.
  always_comb begin
    w_grant     = '0;
    w_push      = 1'b0;
    w_push_word = '0;
    for (int unsigned i = 0; i < N_CAND; i++) begin
      if (!w_push && w_done[i] && w_can_push) begin
        w_grant[i]  = 1'b1;
        w_push      = 1'b1;
        w_push_word = w_word[i];
      end
    end
  end

  logic [MTC2SL_LEN-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic [CNT_W-1:0]      r_drop_cnt;
  logic [CNT_SUM_W-1:0]  w_drop_sum;

  assign w_full     = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_pop      = (r_count != '0) && io_mtc.i_mtc_ready;
  assign w_can_push = !w_full || w_pop;
  assign w_drop_sum = {1'b0, r_drop_cnt} + CNT_SUM_W'($countones(w_drop));

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_word;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PTR_W + 1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PTR_W + 1)'(1);
      r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
    end
  end

  assign io_mtc.o_mtc_valid = (r_count != '0);
  assign io_mtc.o_mtc       = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign io_mtc.o_fifo_full = w_full;
  assign io_mtc.o_drop_cnt  = r_drop_cnt;
endmodule

// File: doc/mtc_builder_arb.md
Name: mtc_builder_arb

Overview:
- Parametrised successor MTC builder. Sits between the SLC pipeline (PL2MTC) and the pT-calc blocks (PTCALC2MTC) on one side and the SL link (MTC2SL) on the other.
- Each candidate lane holds its SLC, waits a variable number of cycles for its pT-calc result (selected by process channel), and formats the MTC word. Proc-flag encoding is unchanged from the current builder, plus a new timeout code.
- Finished MTCs are arbitrated into a FWFT FIFO and leave on one valid/ready stream, so N_CAND and N_PTCALC can differ and pT latency no longer has to be fixed.

Parameters:
- N_CAND, 3, number of SLC candidate lanes.
- N_PTCALC, 3, number of pT-calc result lanes; process channel indexes these.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, minimum 2.
- TIMEOUT, 64, cycles a lane waits for pT before a forced emit; minimum 1.
- CNT_W, 16, width of the drop counter.

Ports:
- clock  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- slc  in  PL2MTC_LEN x N_CAND  SLC candidates; valid bit at PL2MTC_DATA_VALID_MSB.
- ptcalc  in  PTCALC2MTC_LEN x N_PTCALC  pT results.
- ptcalc_valid  in  N_PTCALC  one-cycle strobe per pT lane.
- mtc  out  MTC2SL_LEN  head MTC word; MSB = valid.
- mtc_valid  out  1  head entry present.
- mtc_ready  in  1  consumer accepts.
- drop_cnt  out  CNT_W  candidates dropped because their lane was busy.
- fifo_full  out  1  FIFO full.

Behaviour:
- Reset values: all lanes IDLE, FIFO empty, mtc=0, mtc_valid=0, drop_cnt=0, fifo_full=0. Reset mid-operation discards all pending candidates and FIFO contents.
- Per-lane FSM, states IDLE, WAIT_PT, DONE:
  - IDLE, slc valid, PL2MTC_BUSY_LSB=1: latch slc, MDT fields and procflags forced 0, go to DONE.
  - IDLE, slc valid, busy=0: latch slc and process channel ch, clear timer, go to WAIT_PT.
  - WAIT_PT, ptcalc_valid[ch]=1: latch ptcalc[ch], format, go to DONE.
  - WAIT_PT, timer reaches TIMEOUT-1 with no strobe: MDT fields 0, procflags=0xE, go to DONE.
  - WAIT_PT: timer increments every cycle; it saturates and does not wrap.
  - DONE: hold until granted a FIFO write, then go to IDLE.
  - ch >= N_PTCALC: treated as a timeout immediately (procflags 0xE) the cycle after capture.
- Lane occupied: slc valid arriving while the lane is in WAIT_PT or DONE is dropped and drop_cnt increments. drop_cnt saturates at all-ones. A lane in DONE that is granted this cycle still counts as occupied.
- Multiple lanes see the same strobe: all of them capture it.
- Formatting:
  - Common field copied from slc. Charge..eta and quality..nsegments copied from ptcalc.
  - procflags priority:
    - muid SLID != 0 -> 3.
    - Else pt != 0 -> 1 if ptthresh >= SL ptthresh (unsigned), else 2.
    - Else cointype == 0 -> nseg 0 -> 4; nseg 1 -> 5; otherwise 0xF.
    - Else nseg > 2 -> 6.
    - Else 0xF.
  - Reserved bits 0. Stored word MSB = 1.
- Arbitration: one FIFO write per cycle. Lowest-index DONE lane wins when the FIFO is not full. With FIFO full, all DONE lanes hold and timers of WAIT_PT lanes keep running.
- FIFO: first-word-fall-through.
  - Write at edge E makes mtc_valid high after E if the FIFO was empty.
  - Pop on mtc_valid & mtc_ready.
  - Simultaneous push and pop when full is allowed; occupancy stays at FIFO_DEPTH.
  - mtc = 0 whenever mtc_valid = 0.
- Latency: ptcalc_valid sampled at edge E0 -> lane DONE after E0 -> FIFO write at E1 -> mtc_valid after E1, when the FIFO is empty and no other lane wins first.

Optional Feature:
- MTC_BUILDER_TIMEOUT_EN.
- Defined: timeout behaviour as above, procflags 0xE.
- Undefined: no timer logic and no timeout. WAIT_PT waits indefinitely, and ch >= N_PTCALC is dropped to IDLE with drop_cnt incremented.

Test Plan:
- Lane0 slc valid, ch=1, busy=0; ptcalc_valid[1] 5 cycles later with pt=100, ptthresh=3, SL ptthresh=2, SLID=0 -> mtc_valid 2 cycles after strobe, procflags=1, mtc MSB=1.
- Lane2 slc with busy=1 -> MTC emitted with MDT fields 0, procflags 0, common field equal to input.
- Lanes 0,1,2 all finish in the same cycle, mtc_ready=1 -> output order lane0, lane1, lane2 on consecutive cycles.
- Lane1 waits with no strobe, macro defined, TIMEOUT=64 -> emitted procflags=0xE, 64 cycles after capture plus 2.
- mtc_ready=0, 9 candidates completed, FIFO_DEPTH=8 -> fifo_full=1, 9th lane holds in DONE. New slc on that lane is dropped, drop_cnt=1. Release ready -> all 9 emitted in order.
- rst asserted with 3 entries in FIFO and 2 lanes in WAIT_PT -> next cycle mtc_valid=0, drop_cnt=0; later strobes produce no output.
